serial_reg_arbiter: RTL

SERIAL_REG_ARBITER -- requirements
Module: serial_reg_arbiter

---
 rtl/serial_reg_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/serial_reg_arbiter.sv
// Two-requester round-robin arbiter driving a bank of bit-serial registers.
// Writes shift a word out LSB first; reads strobe the register, then shift its word in.
module serial_reg_arbiter #(
    parameter int unsigned SIZE = 4,
    parameter int unsigned NREG = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 req,
    input  logic [1:0]                 req_we,
    input  logic [2*$clog2(NREG)-1:0]  req_addr,
    input  logic [2*SIZE-1:0]          req_wdata,
    output logic [1:0]                 gnt,
    output logic [1:0]                 done,
    output logic [SIZE-1:0]            rdata,
    output logic                       busy,
    output logic [NREG-1:0]            sr_write,
    output logic [NREG-1:0]            sr_read,
    output logic                       sr_din,
    input  logic [NREG-1:0]            sr_dout
);

    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned CW = $clog2(SIZE) + 1;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StWrite   = 3'd1;
    localparam logic [2:0] StRdStart = 3'd2;
    localparam logic [2:0] StRead    = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic            owner_q, owner_d;
    logic            prio_q, prio_d;
    logic [SIZE-1:0] wdata_q, wdata_d;
    logic [SIZE-1:0] shift_q, shift_d;
    logic [SIZE-1:0] rdata_q, rdata_d;

    logic            grant_any;
    logic            grant_sel;
    logic            last_bit;
    logic            bit_in;
    logic [SIZE-1:0] bit_mask;
    logic [SIZE-1:0] wdata_shifted;

    // prio_q names the requester that wins a tie; it points away from the last winner.
    always_comb begin
        grant_sel = 1'b0;
        case (req)
            2'b01:   grant_sel = 1'b0;
            2'b10:   grant_sel = 1'b1;
            2'b11:   grant_sel = prio_q;
            default: grant_sel = 1'b0;
        endcase
        grant_any = (state_q == StIdle) && (|req) && !rst;
    end

    assign gnt           = grant_any ? (2'b01 << grant_sel) : 2'b00;
    assign last_bit      = (cnt_q == CW'(SIZE - 1));
    assign bit_in        = sr_dout[addr_q];
    assign bit_mask      = SIZE'(1) << cnt_q;
    assign wdata_shifted = wdata_q >> cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        wdata_d = wdata_q;
        shift_d = shift_q;
        rdata_d = rdata_q;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (grant_any) begin
                    owner_d = grant_sel;
                    prio_d  = ~grant_sel;
                    addr_d  = grant_sel ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
                    wdata_d = grant_sel ? req_wdata[2*SIZE-1:SIZE] : req_wdata[SIZE-1:0];
                    we_d    = req_we[grant_sel];
                    state_d = req_we[grant_sel] ? StWrite : StRdStart;
                end
            end
            StWrite: begin
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StRdStart: begin
                cnt_d   = '0;
                shift_d = '0;
                state_d = StRead;
            end
            StRead: begin
                shift_d = (shift_q & ~bit_mask) | (bit_mask & {SIZE{bit_in}});
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    // Load with the final bit merged so rdata is valid while done is high.
                    rdata_d = shift_d;
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            wdata_q <= '0;
            shift_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            wdata_q <= wdata_d;
            shift_q <= shift_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        busy     = (state_q != StIdle);
        sr_write = (state_q == StWrite) ? (NREG'(1) << addr_q) : '0;
        sr_read  = (state_q == StRdStart) ? (NREG'(1) << addr_q) : '0;
        sr_din   = (state_q == StWrite) ? wdata_shifted[0] : 1'b0;
        done     = (state_q == StDone) ? (2'b01 << owner_q) : 2'b00;
        rdata    = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(gnt) && $onehot0(done));
            assert ($onehot0(sr_write | sr_read));
        end
    end

endmodule
